// File: rtl/vip_featuremap_channel_packer.sv
// rtl/vip_featuremap_channel_packer.sv - gathers 8 interleaved channel words into one parallel vector write
// Counts vectors per frame and pulses frame_done after the last vector of each frame.
module vip_featuremap_channel_packer #(
   parameter int DWIDTH  = 32,
   parameter int PIXELS  = 12544,
   parameter int PCWIDTH = 14
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DWIDTH-1:0]  ff_rdata,
   input  logic               ff_empty,
   output logic               ff_rdreq,
   output logic [DWIDTH-1:0]  fifo_in_data0,
   output logic [DWIDTH-1:0]  fifo_in_data1,
   output logic [DWIDTH-1:0]  fifo_in_data2,
   output logic [DWIDTH-1:0]  fifo_in_data3,
   output logic [DWIDTH-1:0]  fifo_in_data4,
   output logic [DWIDTH-1:0]  fifo_in_data5,
   output logic [DWIDTH-1:0]  fifo_in_data6,
   output logic [DWIDTH-1:0]  fifo_in_data7,
   output logic               fifo_in_wrreq,
   input  logic               fifo_in_full,
   output logic [PCWIDTH-1:0] pixel_cnt,
   output logic               frame_done
);

   typedef enum logic {FILL, PUSH} state_t;

   localparam logic [PCWIDTH-1:0] LAST_PIX = PCWIDTH'(PIXELS - 1);

   state_t             state_q, state_d;
   logic [3:0]         req_cnt_q, req_cnt_d;
   logic [3:0]         cap_cnt_q, cap_cnt_d;
   logic               rd_pend_q, rd_pend_d;
   logic [DWIDTH-1:0]  lane_q [8];
   logic [DWIDTH-1:0]  lane_d [8];
   logic [PCWIDTH-1:0] pixel_cnt_q, pixel_cnt_d;
   logic               frame_done_q, frame_done_d;
   logic               rd_issue;
   logic               wr_issue;

   always_comb begin
      state_d      = state_q;
      req_cnt_d    = req_cnt_q;
      cap_cnt_d    = cap_cnt_q;
      rd_pend_d    = 1'b0;
      lane_d       = lane_q;
      pixel_cnt_d  = pixel_cnt_q;
      frame_done_d = 1'b0;
      rd_issue     = 1'b0;
      wr_issue     = 1'b0;
      case (state_q)
         FILL: begin
            rd_issue  = !ff_empty && (req_cnt_q < 4'd8);
            rd_pend_d = rd_issue;
            if (rd_issue) begin
               req_cnt_d = req_cnt_q + 4'd1;
            end
            // Read data lands one cycle after its request; cap_cnt picks the lane.
            if (rd_pend_q) begin
               lane_d[cap_cnt_q[2:0]] = ff_rdata;
               cap_cnt_d              = cap_cnt_q + 4'd1;
               if (cap_cnt_q == 4'd7) begin
                  state_d = PUSH;
               end
            end
         end
         PUSH: begin
            wr_issue = !fifo_in_full;
            if (wr_issue) begin
               req_cnt_d = 4'd0;
               cap_cnt_d = 4'd0;
               state_d   = FILL;
               if (pixel_cnt_q == LAST_PIX) begin
                  pixel_cnt_d  = '0;
                  frame_done_d = 1'b1;
               end else begin
                  pixel_cnt_d = pixel_cnt_q + PCWIDTH'(1);
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= FILL;
         req_cnt_q    <= 4'd0;
         cap_cnt_q    <= 4'd0;
         rd_pend_q    <= 1'b0;
         pixel_cnt_q  <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         req_cnt_q    <= req_cnt_d;
         cap_cnt_q    <= cap_cnt_d;
         rd_pend_q    <= rd_pend_d;
         pixel_cnt_q  <= pixel_cnt_d;
         frame_done_q <= frame_done_d;
         lane_q       <= lane_d;
      end
   end

   // Gated by reset so no word is popped upstream while the packer is held.
   assign ff_rdreq      = rd_issue && !reset;
   assign fifo_in_wrreq = wr_issue;
   assign fifo_in_data0 = lane_q[0];
   assign fifo_in_data1 = lane_q[1];
   assign fifo_in_data2 = lane_q[2];
   assign fifo_in_data3 = lane_q[3];
   assign fifo_in_data4 = lane_q[4];
   assign fifo_in_data5 = lane_q[5];
   assign fifo_in_data6 = lane_q[6];
   assign fifo_in_data7 = lane_q[7];
   assign pixel_cnt     = pixel_cnt_q;
   assign frame_done    = frame_done_q;

endmodule
